// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU operation set and ALU helper.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic logic [XLEN-1:0] alu_exec(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return XLEN'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

endpackage

// File: rtl/regs.sv
// 32 x 32 register file: two combinational read ports, one write port, x0 hard-wired to zero.
module regs
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] regs [32];

    // NOTE: unlike the data RAM, this array is small enough that clearing it on reset is cheap and expected.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/riscv.sv
// Single-cycle RV32I core. Define SOC_TRACE_EN to print a retire trace each cycle.
module riscv
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    output logic            dmem_we
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_data, rs2_data, rd_data, pc_next, pc_plus4, ld_byte, ld_half;
    logic rd_we, taken;
    alu_op_t alu_op;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc_plus4  = pc + 32'd4;
    assign dmem_addr = rs1_data + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign ld_byte   = dmem_rdata >> {dmem_addr[1:0], 3'b000};
    assign ld_half   = dmem_rdata >> {dmem_addr[1], 4'b0000};

    regs regs_inst (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (rd_we),
        .rd_addr  (rd),
        .rd_data  (rd_data)
    );

    always_comb begin
        case (f3)
            F3_BEQ:  taken = rs1_data == rs2_data;
            F3_BNE:  taken = rs1_data != rs2_data;
            F3_BLT:  taken = $signed(rs1_data) <  $signed(rs2_data);
            F3_BGE:  taken = $signed(rs1_data) >= $signed(rs2_data);
            F3_BLTU: taken = rs1_data <  rs2_data;
            F3_BGEU: taken = rs1_data >= rs2_data;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (f3)
            F3_ADD:  alu_op = (opcode == OP_REG && instr[30]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = instr[30] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pc_next    = pc_plus4;
        rd_we      = 1'b0;
        rd_data    = '0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_wdata = rs2_data;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_data = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_data = pc + imm_u; end
            OP_JAL:    begin rd_we = 1'b1; rd_data = pc_plus4; pc_next = pc + imm_j; end
            OP_JALR:   begin rd_we = 1'b1; rd_data = pc_plus4; pc_next = (rs1_data + imm_i) & ~32'd1; end
            OP_BRANCH: if (taken) pc_next = pc + imm_b;
            OP_IMM:    begin rd_we = 1'b1; rd_data = alu_exec(alu_op, rs1_data, imm_i); end
            OP_REG:    begin rd_we = 1'b1; rd_data = alu_exec(alu_op, rs1_data, rs2_data); end
            OP_LOAD: begin
                rd_we = 1'b1;
                case (f3)
                    F3_B:    rd_data = {{24{ld_byte[7]}}, ld_byte[7:0]};
                    F3_BU:   rd_data = {24'b0, ld_byte[7:0]};
                    F3_H:    rd_data = {{16{ld_half[15]}}, ld_half[15:0]};
                    F3_HU:   rd_data = {16'b0, ld_half[15:0]};
                    default: rd_data = dmem_rdata;
                endcase
            end
            OP_STORE: begin
                dmem_we = 1'b1;
                case (f3)
                    F3_B:    begin dmem_be = 4'b0001 << dmem_addr[1:0]; dmem_wdata = {4{rs2_data[7:0]}}; end
                    F3_H:    begin dmem_be = dmem_addr[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{rs2_data[15:0]}}; end
                    F3_W:    dmem_be = 4'b1111;
                    default: dmem_be = 4'b0000;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end

`ifdef SOC_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rd_we && rd != 5'd0) $display("pc=%h instr=%h rd=x%0d wdata=%h", pc, instr, rd, rd_data);
            else                     $display("pc=%h instr=%h", pc, instr);
        end
    end
`endif

endmodule

// File: rtl/rom.sv
// Instruction ROM with combinational read; contents are preloaded by the simulation environment.
module rom #(
    parameter int ROM_WORDS = 4096,
    localparam int AW = $clog2(ROM_WORDS)
) (
    input  logic [AW-1:0] word_addr,
    output logic [31:0]   instr
);

    logic [31:0] rom_mem [ROM_WORDS];

    assign instr = rom_mem[word_addr];

endmodule

// File: rtl/riscv_soc.sv
// Harvard RV32I system: core, instruction ROM and byte-enabled data RAM. Trace via SOC_TRACE_EN.
module riscv_soc
    import riscv_pkg::*;
#(
    parameter int               ROM_WORDS = 4096,
    parameter int               RAM_WORDS = 4096,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);

    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [XLEN-1:0] pc, dmem_addr, dmem_rdata, dmem_wdata;
    logic [31:0]     instr;
    logic [3:0]      dmem_be;
    logic            dmem_we;
    logic [RAM_AW-1:0] ram_idx;

    logic [31:0] ram_mem [RAM_WORDS];

    rom #(.ROM_WORDS(ROM_WORDS)) rom_inst (
        .word_addr (pc[ROM_AW+1:2]),
        .instr     (instr)
    );

    riscv #(.RESET_PC(RESET_PC)) riscv_inst (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .instr      (instr),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_we    (dmem_we)
    );

    assign ram_idx    = dmem_addr[RAM_AW+1:2];
    assign dmem_rdata = ram_mem[ram_idx];

    // The RAM keeps its contents across reset; only the store of the reset cycle is suppressed.
    always_ff @(posedge clk) begin
        if (dmem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_be[b]) ram_mem[ram_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_soc.sv
// Scoreboard bench for riscv_soc: directed program in ROM, register checkpoints keyed on pc.
module tb_riscv_soc;

    localparam logic [6:0] OPI = 7'h13, LD = 7'h03, LUI = 7'h37, JALR = 7'h67;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        logic [31:0] at_pc;
        logic [4:0]  rg;
        logic [31:0] exp;
    } chk_t;

    logic clk, rst;
    chk_t sb[$];
    int   n_pass, n_total;

    riscv_soc dut (.clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] s_t(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(logic [12:0] off, logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(logic [20:0] off, logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] u_t(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic put(int addr, logic [31:0] w);
        dut.rom_inst.rom_mem[addr >> 2] = w;
    endtask

    task automatic expect_reg(string name, logic [31:0] at_pc, logic [4:0] rg, logic [31:0] exp);
        chk_t c;
        c.name = name; c.at_pc = at_pc; c.rg = rg; c.exp = exp;
        sb.push_back(c);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_drain(int budget);
        chk_t c;
        for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge clk);
        while (sb.size() > 0) begin
            c = sb.pop_front();
            n_total++;
            $display("FAIL %s: checkpoint pc=%h never reached (pc=%h, x3=%0d), required x%0d=%h",
                     c.name, c.at_pc, dut.riscv_inst.pc, dut.riscv_inst.regs_inst.regs[3], c.rg, c.exp);
        end
    endtask

    // Monitor: whenever the core sits at the head checkpoint's pc, compare that register.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && dut.riscv_inst.pc == sb[0].at_pc) begin
                c = sb.pop_front();
                check(c.name, dut.riscv_inst.regs_inst.regs[c.rg], c.exp);
            end
        end
    end

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        for (int a = 0; a < 4096; a++) put(a * 4, NOP);

        put(0,   32'h0050_0093);                          // addi x1,x0,5
        put(4,   u_t(20'h80000, 5'd2, LUI));
        put(8,   i_t(12'h404, 5'd2, 3'd5, 5'd3, OPI));    // srai x3,x2,4
        put(12,  i_t(12'd1, 5'd0, 3'd3, 5'd4, OPI));      // sltiu x4,x0,1
        put(16,  b_t(13'd8, 5'd0, 5'd0, 3'd0));           // beq x0,x0,+8
        put(20,  i_t(12'd1, 5'd0, 3'd0, 5'd5, OPI));
        put(24,  j_t(21'd12, 5'd1));                      // jal x1,+12
        put(28,  i_t(12'd1, 5'd0, 3'd0, 5'd6, OPI));
        put(32,  i_t(12'd2, 5'd0, 3'd0, 5'd6, OPI));
        put(36,  i_t(12'd53, 5'd0, 3'd0, 5'd7, OPI));
        put(40,  i_t(12'd0, 5'd7, 3'd0, 5'd8, JALR));     // jalr x8,0(x7) -> 52
        put(44,  i_t(12'd1, 5'd0, 3'd0, 5'd9, OPI));
        put(48,  i_t(12'd2, 5'd0, 3'd0, 5'd9, OPI));
        put(52,  u_t(20'h12345, 5'd10, LUI));
        put(56,  i_t(12'h678, 5'd10, 3'd0, 5'd10, OPI));
        put(60,  i_t(12'h100, 5'd0, 3'd0, 5'd11, OPI));
        put(64,  s_t(12'd0, 5'd10, 5'd11, 3'd2));         // sw x10,0(x11)
        put(68,  i_t(12'd3, 5'd11, 3'd0, 5'd12, LD));     // lb 0x103
        put(72,  i_t(12'd2, 5'd11, 3'd1, 5'd13, LD));     // lh 0x102
        put(76,  i_t(12'h0AA, 5'd0, 3'd0, 5'd14, OPI));
        put(80,  s_t(12'd1, 5'd14, 5'd11, 3'd0));         // sb 0x101
        put(84,  i_t(12'd0, 5'd11, 3'd2, 5'd15, LD));     // lw 0x100
        put(88,  i_t(12'd1, 5'd11, 3'd0, 5'd16, LD));     // lb 0x101
        put(92,  i_t(12'd1, 5'd11, 3'd4, 5'd17, LD));     // lbu 0x101
        put(96,  i_t(12'd7, 5'd0, 3'd0, 5'd0, OPI));      // addi x0,x0,7
        put(100, 32'h0000_0073);                          // ecall
        put(104, 32'hFFFF_FFFF);
        // Mini self-checking test: x3 = test number, x26 = done, x27 = pass.
        put(108, i_t(12'd2, 5'd0, 3'd0, 5'd3, OPI));
        put(112, i_t(12'hFFF, 5'd0, 3'd0, 5'd18, OPI));
        put(116, r_t(7'h00, 5'd18, 5'd18, 3'd0, 5'd19));
        put(120, i_t(12'hFFE, 5'd0, 3'd0, 5'd20, OPI));
        put(124, b_t(13'd92, 5'd19, 5'd20, 3'd1));
        put(128, i_t(12'd3, 5'd0, 3'd0, 5'd3, OPI));
        put(132, r_t(7'h20, 5'd18, 5'd0, 3'd0, 5'd21));
        put(136, i_t(12'd1, 5'd0, 3'd0, 5'd20, OPI));
        put(140, b_t(13'd76, 5'd21, 5'd20, 3'd1));
        put(144, i_t(12'd4, 5'd0, 3'd0, 5'd3, OPI));
        put(148, r_t(7'h00, 5'd0, 5'd18, 3'd2, 5'd22));
        put(152, r_t(7'h00, 5'd0, 5'd18, 3'd3, 5'd23));
        put(156, b_t(13'd60, 5'd22, 5'd20, 3'd1));
        put(160, b_t(13'd56, 5'd23, 5'd0, 3'd1));
        put(164, i_t(12'd5, 5'd0, 3'd0, 5'd3, OPI));
        put(168, b_t(13'd8, 5'd18, 5'd0, 3'd4));
        put(172, j_t(21'd44, 5'd0));
        put(176, b_t(13'd8, 5'd18, 5'd0, 3'd7));
        put(180, j_t(21'd36, 5'd0));
        put(184, i_t(12'd6, 5'd0, 3'd0, 5'd3, OPI));
        put(188, i_t(12'h0F0, 5'd18, 3'd4, 5'd24, OPI));
        put(192, i_t(12'd28, 5'd24, 3'd5, 5'd25, OPI));
        put(196, i_t(12'd15, 5'd0, 3'd0, 5'd20, OPI));
        put(200, b_t(13'd16, 5'd25, 5'd20, 3'd1));
        put(204, i_t(12'd1, 5'd0, 3'd0, 5'd26, OPI));
        put(208, i_t(12'd1, 5'd0, 3'd0, 5'd27, OPI));
        put(212, j_t(21'd0, 5'd0));
        put(216, i_t(12'd1, 5'd0, 3'd0, 5'd26, OPI));
        put(220, i_t(12'd0, 5'd0, 3'd0, 5'd27, OPI));
        put(224, j_t(21'd0, 5'd0));

        expect_reg("reset_first_addi_x1", 32'd4,   5'd1,  32'd5);
        expect_reg("reset_x2_zero",       32'd4,   5'd2,  32'd0);
        expect_reg("reset_x31_zero",      32'd4,   5'd31, 32'd0);
        expect_reg("lui_x2",              32'd16,  5'd2,  32'h8000_0000);
        expect_reg("srai_x3",             32'd16,  5'd3,  32'hF800_0000);
        expect_reg("sltiu_x4",            32'd16,  5'd4,  32'd1);
        expect_reg("beq_skip_x5",         32'd36,  5'd5,  32'd0);
        expect_reg("jal_skip_x6",         32'd36,  5'd6,  32'd0);
        expect_reg("jal_link_x1",         32'd36,  5'd1,  32'd28);
        expect_reg("jalr_link_x8",        32'd52,  5'd8,  32'd44);
        expect_reg("jalr_skip_x9",        32'd52,  5'd9,  32'd0);
        expect_reg("lb_0x103",            32'd88,  5'd12, 32'h0000_0012);
        expect_reg("lh_0x102",            32'd88,  5'd13, 32'h0000_1234);
        expect_reg("sb_then_lw",          32'd88,  5'd15, 32'h1234_AA78);
        expect_reg("lb_sign_0x101",       32'd108, 5'd16, 32'hFFFF_FFAA);
        expect_reg("lbu_0x101",           32'd108, 5'd17, 32'h0000_00AA);
        expect_reg("x0_stays_zero",       32'd108, 5'd0,  32'd0);
        expect_reg("unknown_op_no_write", 32'd108, 5'd31, 32'd0);
        expect_reg("nop_keeps_x7",        32'd108, 5'd7,  32'd53);
        expect_reg("selftest_done_x26",   32'd212, 5'd26, 32'd1);
        expect_reg("selftest_pass_x27",   32'd212, 5'd27, 32'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_drain(10000);

        // Reset mid-execution: registers clear while the core spins in its pass loop.
        @(negedge clk);
        expect_reg("midreset_x1",  32'd0, 5'd1,  32'd0);
        expect_reg("midreset_x10", 32'd0, 5'd10, 32'd0);
        expect_reg("midreset_x26", 32'd0, 5'd26, 32'd0);
        expect_reg("midreset_x27", 32'd0, 5'd27, 32'd0);
        rst = 1'b1;
        wait_drain(6);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
